// File: rtl/brush_plotter.sv
// -----------------------------------------------------------------------------
// brush_plotter
//
// Purpose:
//   Sits between the cursor datapath and vga_adapter. It turns one cursor
//   position into a square brush "dab" of 1x1..4x4 pixels, or it fills the
//   whole screen with colour 3'b000 (a wipe). Each pixel write leaves as a
//   single registered x/y/colour/plot beat per clock cycle.
//
// Ports:
//   clk     in   1  system clock (CLOCK_50)
//   clear   in   1  synchronous active-high reset; aborts any operation
//   req     in   1  request a dab at (cx,cy); sampled only in IDLE
//   cx      in   8  dab top-left x
//   cy      in   7  dab top-left y
//   clr_in  in   3  dab colour (RGB)
//   size    in   2  brush edge minus 1 (0 -> 1x1 .. 3 -> 4x4)
//   wipe    in   1  full-screen fill request; beats req in IDLE, aborts a dab
//   busy    out  1  high while a dab or wipe is running
//   x       out  8  pixel x to vga_adapter
//   y       out  7  pixel y to vga_adapter
//   colour  out  3  pixel colour to vga_adapter
//   plot    out  1  pixel write strobe to vga_adapter
//   done    out  1  one-cycle pulse after the last beat of a dab or wipe
//
// Handshake: req/wipe are level inputs sampled on each posedge. A request
//   counts only when the FSM can take it (IDLE, or wipe during a dab). A
//   beat is valid exactly in the cycles where plot=1; the sink (vga_adapter)
//   always accepts, so there is no ready.
//
// Configuration macro: BRUSH_CLIP_EN
//   defined   -> origin used as given; off-screen beats keep their cycle but
//                drive plot=0.
//   undefined -> origin clamped at latch time so the whole brush is on-screen.
// -----------------------------------------------------------------------------
module brush_plotter #(
    parameter int unsigned X_MAX     = 160,
    parameter int unsigned Y_MAX     = 120,
    parameter int unsigned MAX_BRUSH = 4
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       req,
    input  logic [7:0] cx,
    input  logic [6:0] cy,
    input  logic [2:0] clr_in,
    input  logic [1:0] size,
    input  logic       wipe,
    output logic       busy,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DAB  = 2'd1,
        S_WIPE = 2'd2
    } state_t;

    localparam logic [1:0] MAX_NM1 = 2'(MAX_BRUSH - 1);
    localparam logic [7:0] X_LAST  = 8'(X_MAX - 1);
    localparam logic [6:0] Y_LAST  = 7'(Y_MAX - 1);

    state_t     state_q, state_d;
    logic [7:0] ox_q, ox_d;
    logic [6:0] oy_q, oy_d;
    logic [2:0] col_q, col_d;
    logic [1:0] nm1_q, nm1_d;
    logic [1:0] dx_q, dx_d;
    logic [1:0] dy_q, dy_d;
    logic [7:0] wx_q, wx_d;
    logic [6:0] wy_q, wy_d;

    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic [2:0] colour_q, colour_d;
    logic       plot_q, plot_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    // Values latched when a dab is accepted.
    logic [1:0] nm1_in;
    logic [7:0] ox_in;
    logic [6:0] oy_in;
    logic       emit_dab;
    logic       emit_wipe;

`ifdef BRUSH_CLIP_EN
    logic [8:0] px;
    logic [7:0] py;
`else
    logic [8:0] x_lim;
    logic [7:0] y_lim;
`endif

    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign busy   = busy_q;
    assign done   = done_q;

    always_comb begin
        // Brush edge never exceeds MAX_BRUSH, whatever arrives on size.
        nm1_in = (size > MAX_NM1) ? MAX_NM1 : size;
`ifdef BRUSH_CLIP_EN
        ox_in = cx;
        oy_in = cy;
`else
        // Largest origin that still keeps the full n x n brush on-screen.
        x_lim = 9'(X_MAX - 1) - {7'd0, nm1_in};
        y_lim = 8'(Y_MAX - 1) - {6'd0, nm1_in};
        ox_in = ({1'b0, cx} > x_lim) ? x_lim[7:0] : cx;
        oy_in = ({1'b0, cy} > y_lim) ? y_lim[6:0] : cy;
`endif
    end

    always_comb begin
        state_d   = state_q;
        ox_d      = ox_q;
        oy_d      = oy_q;
        col_d     = col_q;
        nm1_d     = nm1_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        wx_d      = wx_q;
        wy_d      = wy_q;
        x_d       = x_q;
        y_d       = y_q;
        colour_d  = colour_q;
        plot_d    = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        emit_dab  = 1'b0;
        emit_wipe = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (wipe) begin
                    state_d   = S_WIPE;
                    wx_d      = 8'd0;
                    wy_d      = 7'd0;
                    emit_wipe = 1'b1;
                end else if (req) begin
                    state_d  = S_DAB;
                    ox_d     = ox_in;
                    oy_d     = oy_in;
                    col_d    = clr_in;
                    nm1_d    = nm1_in;
                    dx_d     = 2'd0;
                    dy_d     = 2'd0;
                    emit_dab = 1'b1;
                end
            end
            S_DAB: begin
                // Counters hold the beat currently on the outputs.
                if (wipe) begin
                    state_d   = S_WIPE;
                    wx_d      = 8'd0;
                    wy_d      = 7'd0;
                    emit_wipe = 1'b1;
                end else if (dx_q == nm1_q && dy_q == nm1_q) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (dx_q == nm1_q) begin
                    dx_d     = 2'd0;
                    dy_d     = dy_q + 2'd1;
                    emit_dab = 1'b1;
                end else begin
                    dx_d     = dx_q + 2'd1;
                    emit_dab = 1'b1;
                end
            end
            S_WIPE: begin
                if (wx_q == X_LAST && wy_q == Y_LAST) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (wx_q == X_LAST) begin
                    wx_d      = 8'd0;
                    wy_d      = wy_q + 7'd1;
                    emit_wipe = 1'b1;
                end else begin
                    wx_d      = wx_q + 8'd1;
                    emit_wipe = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef BRUSH_CLIP_EN
        // Full-width sums so an off-screen pixel is never wrapped back on.
        px = {1'b0, ox_d} + {7'd0, dx_d};
        py = {1'b0, oy_d} + {6'd0, dy_d};
`endif

        if (emit_dab) begin
            colour_d = col_d;
            busy_d   = 1'b1;
`ifdef BRUSH_CLIP_EN
            x_d    = px[7:0];
            y_d    = py[6:0];
            plot_d = (px < 9'(X_MAX)) && (py < 8'(Y_MAX));
`else
            x_d    = ox_d + {6'd0, dx_d};
            y_d    = oy_d + {5'd0, dy_d};
            plot_d = 1'b1;
`endif
        end else if (emit_wipe) begin
            x_d      = wx_d;
            y_d      = wy_d;
            colour_d = 3'b000;
            plot_d   = 1'b1;
            busy_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q  <= S_IDLE;
            ox_q     <= 8'd0;
            oy_q     <= 7'd0;
            col_q    <= 3'd0;
            nm1_q    <= 2'd0;
            dx_q     <= 2'd0;
            dy_q     <= 2'd0;
            wx_q     <= 8'd0;
            wy_q     <= 7'd0;
            x_q      <= 8'd0;
            y_q      <= 7'd0;
            colour_q <= 3'd0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ox_q     <= ox_d;
            oy_q     <= oy_d;
            col_q    <= col_d;
            nm1_q    <= nm1_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            wx_q     <= wx_d;
            wy_q     <= wy_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_brush_plotter.sv
// -----------------------------------------------------------------------------
// tb_brush_plotter
//
// Self-checking bench for brush_plotter. Expected pixel beats {x,y,colour}
// are queued by the drivers and popped by a negedge monitor whenever plot=1.
// Honours BRUSH_CLIP_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_brush_plotter;

  localparam int X_MAX = 160;
  localparam int Y_MAX = 120;
  localparam int WIPE_BEATS = X_MAX * Y_MAX;

  logic       clk = 1'b0;
  logic       clear;
  logic       req;
  logic [7:0] cx;
  logic [6:0] cy;
  logic [2:0] clr_in;
  logic [1:0] size;
  logic       wipe;
  logic       busy;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       done;

  int checks = 0;
  int errors = 0;

  logic [17:0] exp_q[$];

  brush_plotter #(.X_MAX(X_MAX), .Y_MAX(Y_MAX), .MAX_BRUSH(4)) dut (
    .clk    (clk),
    .clear  (clear),
    .req    (req),
    .cx     (cx),
    .cy     (cy),
    .clr_in (clr_in),
    .size   (size),
    .wipe   (wipe),
    .busy   (busy),
    .x      (x),
    .y      (y),
    .colour (colour),
    .plot   (plot),
    .done   (done)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [17:0] e;
    if (plot === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", {14'd0, x, y, colour}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("beat", {14'd0, x, y, colour}, {14'd0, e});
      end
    end
  end

  // ---------------- reference model ----------------
  task automatic push_dab(input int ccx, input int ccy, input int sz, input logic [2:0] col);
    int n, ox, oy, px, py;
    n  = sz + 1;
    ox = ccx;
    oy = ccy;
`ifndef BRUSH_CLIP_EN
    if (ox > X_MAX - n) ox = X_MAX - n;
    if (oy > Y_MAX - n) oy = Y_MAX - n;
`endif
    for (int dy = 0; dy < n; dy++) begin
      for (int dx = 0; dx < n; dx++) begin
        px = ox + dx;
        py = oy + dy;
        if (px < X_MAX && py < Y_MAX) begin
          exp_q.push_back({px[7:0], py[6:0], col});
        end
      end
    end
  endtask

  task automatic push_wipe(input int beats);
    int k;
    k = 0;
    for (int yy = 0; yy < Y_MAX; yy++) begin
      for (int xx = 0; xx < X_MAX; xx++) begin
        if (k < beats) exp_q.push_back({xx[7:0], yy[6:0], 3'b000});
        k++;
      end
    end
  endtask

  // ---------------- drivers ----------------
  // All drivers start and end just after a negedge.
  task automatic run_dab(input int ccx, input int ccy, input int sz, input logic [2:0] col);
    int cyc, first;
    push_dab(ccx, ccy, sz, col);
    cx = ccx[7:0]; cy = ccy[6:0]; size = sz[1:0]; clr_in = col;
    req = 1'b1;
    cyc = 0;
    first = 0;
    do begin
      @(negedge clk);
      req = 1'b0;
      cyc++;
      if (plot && first == 0) first = cyc;
      if (!done) check("dab_busy", {31'd0, busy}, 32'd1);
    end while (!done && cyc < 100);
    check("dab_cycles", cyc, (sz + 1) * (sz + 1) + 1);
    check("dab_first_beat", first, 1);
    check("dab_done_idle", {30'd0, plot, busy}, 32'd0);
    check("dab_queue_empty", exp_q.size(), 0);
    @(negedge clk);
    check("dab_done_pulse", {31'd0, done}, 32'd0);
  endtask

  task automatic run_wipe();
    int cyc;
    push_wipe(WIPE_BEATS);
    wipe = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      wipe = 1'b0;
      cyc++;
      if (!done) check("wipe_busy", {31'd0, busy}, 32'd1);
    end while (!done && cyc < WIPE_BEATS + 50);
    check("wipe_cycles", cyc, WIPE_BEATS + 1);
    check("wipe_done_idle", {30'd0, plot, busy}, 32'd0);
    check("wipe_queue_empty", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc, beats;
    clear = 1'b1; req = 1'b1; wipe = 1'b1;
    cx = 8'd0; cy = 7'd0; clr_in = 3'd0; size = 2'd0;

    // Reset held with requests asserted: everything stays at zero.
    repeat (2) begin
      @(negedge clk);
      check("reset_outputs", {12'd0, x, y, colour, plot, busy, done}, 32'd0);
    end
    clear = 1'b0; req = 1'b0; wipe = 1'b0;
    @(negedge clk);
    check("idle_after_reset", {12'd0, x, y, colour, plot, busy, done}, 32'd0);

    // Basic 2x2 dab.
    run_dab(10, 20, 1, 3'b100);

    // Edge dab (clamped or clipped depending on the build).
    run_dab(158, 118, 3, 3'b011);
    run_dab(159, 0, 2, 3'b001);
    run_dab(0, 119, 0, 3'b111);

    // A few random dabs.
    for (int i = 0; i < 6; i++) begin
      run_dab($urandom_range(0, X_MAX - 1), $urandom_range(0, Y_MAX - 1),
              $urandom_range(0, 3), 3'($urandom_range(0, 7)));
    end

    // Full wipe.
    run_wipe();

    // Wipe during the 2nd beat of a 4x4 dab aborts it.
    exp_q.push_back({8'd30, 7'd40, 3'b010});
    exp_q.push_back({8'd31, 7'd40, 3'b010});
    cx = 8'd30; cy = 7'd40; size = 2'd3; clr_in = 3'b010;
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd1);
    push_wipe(WIPE_BEATS);
    wipe = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      wipe = 1'b0;
      cyc++;
    end while (!done && cyc < WIPE_BEATS + 50);
    check("abort_wipe_cycles", cyc, WIPE_BEATS + 1);
    check("abort_queue_empty", exp_q.size(), 0);
    @(negedge clk);

    // req+wipe together -> wipe; req/wipe during wipe ignored; clear at beat 100.
    push_wipe(100);
    cx = 8'd50; cy = 7'd50; size = 2'd2; clr_in = 3'b101;
    req = 1'b1; wipe = 1'b1;
    cyc = 0;
    beats = 0;
    do begin
      @(negedge clk);
      req = 1'b0; wipe = 1'b0;
      cyc++;
      if (plot) beats++;
      if (beats == 50) begin
        req = 1'b1; wipe = 1'b1;
      end
    end while (beats < 100 && cyc < 500);
    check("prio_beats_seen", beats, 100);
    check("prio_no_done", {31'd0, done}, 32'd0);
    req = 1'b0; wipe = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    check("clear_abort", {12'd0, x, y, colour, plot, busy, done}, 32'd0);
    check("clear_queue_empty", exp_q.size(), 0);
    clear = 1'b0;
    @(negedge clk);
    check("clear_idle", {29'd0, plot, busy, done}, 32'd0);

    // Normal operation after the aborted wipe.
    run_dab(100, 60, 2, 3'b110);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
